// File: rtl/multi_cycle_alu.sv
// Multi-cycle streaming ALU: operands arrive as little-endian chunks, the full-width
// result is computed (shift-add for MUL) and streamed out LSB chunk first.
module multi_cycle_alu #(
    parameter int OPERAND_BUS_WIDTH      = 8,
    parameter int OPERAND_MAX_DATA_WIDTH = 32,
    parameter int RESULT_BUS_WIDTH       = 8,
    parameter int RESULT_MAX_DATA_WIDTH  = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         operand_valid,
    input  logic [1:0]                   op,
    input  logic [OPERAND_BUS_WIDTH-1:0] a,
    input  logic [OPERAND_BUS_WIDTH-1:0] b,
    input  logic                         operand_last,
    output logic                         ready,
    output logic                         result_valid,
    output logic [RESULT_BUS_WIDTH-1:0]  result,
    output logic                         result_last,
    output logic                         result_rst
);

    localparam int OBW           = OPERAND_BUS_WIDTH;
    localparam int OMDW          = OPERAND_MAX_DATA_WIDTH;
    localparam int RBW           = RESULT_BUS_WIDTH;
    localparam int RMDW          = RESULT_MAX_DATA_WIDTH;
    localparam int NUM_OP_BEATS  = OMDW / OBW;
    localparam int NUM_RES_BEATS = RMDW / RBW;
    localparam int OP_CNT_W      = (NUM_OP_BEATS > 1) ? $clog2(NUM_OP_BEATS) : 1;
    localparam int CALC_CNT_W    = (OMDW > 1) ? $clog2(OMDW) : 1;
    localparam int RES_CNT_W     = $clog2(NUM_RES_BEATS + 1);

    if ((OMDW % OBW) != 0 || (RMDW % RBW) != 0 || RMDW < 2 * OMDW) begin : g_bad_params
        $error("multi_cycle_alu: inconsistent width parameters");
    end

    typedef enum logic [1:0] {IDLE, CALC, OUT, CLR} state_e;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_XOR} op_e;

    state_e                state_q,     state_d;
    op_e                   op_q,        op_d;
    logic [OMDW-1:0]       a_q,         a_d;
    logic [OMDW-1:0]       b_q,         b_d;
    logic [OP_CNT_W-1:0]   beat_cnt_q,  beat_cnt_d;
    logic [CALC_CNT_W-1:0] calc_cnt_q,  calc_cnt_d;
    logic [RMDW-1:0]       acc_q,       acc_d;
    logic [RMDW-1:0]       mcand_q,     mcand_d;
    logic [RES_CNT_W-1:0]  out_cnt_q,   out_cnt_d;
    logic                  ready_q,     ready_d;
    logic                  res_valid_q, res_valid_d;
    logic [RBW-1:0]        result_q,    result_d;
    logic                  res_last_q,  res_last_d;
    logic                  res_rst_q,   res_rst_d;

    logic [RMDW-1:0]       res_full;
    logic [RMDW-1:0]       mul_sum;
    logic                  calc_done;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        beat_cnt_d  = beat_cnt_q;
        calc_cnt_d  = calc_cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        out_cnt_d   = out_cnt_q;
        res_valid_d = 1'b0;
        result_d    = '0;
        res_last_d  = 1'b0;
        res_rst_d   = 1'b0;
        res_full    = '0;
        mul_sum     = acc_q;
        calc_done   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (operand_valid && ready_q) begin
                    if (beat_cnt_q == '0) op_d = op_e'(op);
                    a_d[beat_cnt_q*OBW +: OBW] = a;
                    b_d[beat_cnt_q*OBW +: OBW] = b;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (operand_last || beat_cnt_q == OP_CNT_W'(NUM_OP_BEATS - 1)) begin
                        state_d    = CALC;
                        beat_cnt_d = '0;
                        calc_cnt_d = '0;
                        acc_d      = '0;
                        mcand_d    = RMDW'(a_d);
                    end
                end
            end

            CALC: begin
                unique case (op_q)
                    OP_ADD: begin
                        res_full  = RMDW'(a_q) + RMDW'(b_q);
                        calc_done = 1'b1;
                    end
                    OP_SUB: begin
                        res_full  = RMDW'(a_q) - RMDW'(b_q);
                        calc_done = 1'b1;
                    end
                    OP_XOR: begin
                        res_full  = RMDW'(a_q ^ b_q);
                        calc_done = 1'b1;
                    end
                    OP_MUL: begin
                        // One multiplier bit per cycle; b_q doubles as the shift register.
                        mul_sum    = b_q[0] ? (acc_q + mcand_q) : acc_q;
                        acc_d      = mul_sum;
                        mcand_d    = mcand_q << 1;
                        b_d        = b_q >> 1;
                        calc_cnt_d = calc_cnt_q + 1'b1;
                        if (calc_cnt_q == CALC_CNT_W'(OMDW - 1)) begin
                            res_full  = mul_sum;
                            calc_done = 1'b1;
                        end
                    end
                    default: ;
                endcase

                if (calc_done) begin
                    state_d     = OUT;
                    res_valid_d = 1'b1;
                    result_d    = res_full[RBW-1:0];
                    res_last_d  = (NUM_RES_BEATS == 1);
                    acc_d       = res_full >> RBW;
                    out_cnt_d   = RES_CNT_W'(1);
                end
            end

            OUT: begin
                if (res_last_q) begin
                    state_d    = CLR;
                    res_rst_d  = 1'b1;
                    op_d       = OP_ADD;
                    a_d        = '0;
                    b_d        = '0;
                    beat_cnt_d = '0;
                    calc_cnt_d = '0;
                    acc_d      = '0;
                    mcand_d    = '0;
                    out_cnt_d  = '0;
                end else begin
                    res_valid_d = 1'b1;
                    result_d    = acc_q[RBW-1:0];
                    res_last_d  = (out_cnt_q == RES_CNT_W'(NUM_RES_BEATS - 1));
                    acc_d       = acc_q >> RBW;
                    out_cnt_d   = out_cnt_q + 1'b1;
                end
            end

            CLR: state_d = IDLE;

            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            beat_cnt_q  <= '0;
            calc_cnt_q  <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            out_cnt_q   <= '0;
            ready_q     <= 1'b0;
            res_valid_q <= 1'b0;
            result_q    <= '0;
            res_last_q  <= 1'b0;
            res_rst_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of the others.
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            beat_cnt_q  <= beat_cnt_d;
            calc_cnt_q  <= calc_cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            out_cnt_q   <= out_cnt_d;
            ready_q     <= ready_d;
            res_valid_q <= res_valid_d;
            result_q    <= result_d;
            res_last_q  <= res_last_d;
            res_rst_q   <= res_rst_d;
        end
    end

    assign ready        = ready_q;
    assign result_valid = res_valid_q;
    assign result       = result_q;
    assign result_last  = res_last_q;
    assign result_rst   = res_rst_q;

endmodule

// File: tb/tb_multi_cycle_alu.sv
// Scoreboard bench for multi_cycle_alu: expected chunks are queued when a transaction
// is driven and compared as the DUT streams them out.
`timescale 1ns/1ps
module tb_multi_cycle_alu;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       operand_valid = 1'b0;
    logic [1:0] op = 2'd0;
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd0;
    logic       operand_last = 1'b0;
    logic       ready;
    logic       result_valid;
    logic [7:0] result;
    logic       result_last;
    logic       result_rst;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } sb_entry_t;

    sb_entry_t sb[$];
    int        checks = 0;
    int        errors = 0;
    logic      prev_last = 1'b0;

    multi_cycle_alu #(
        .OPERAND_BUS_WIDTH(8), .OPERAND_MAX_DATA_WIDTH(32),
        .RESULT_BUS_WIDTH(8), .RESULT_MAX_DATA_WIDTH(64)
    ) dut (
        .clk(clk), .rst(rst), .operand_valid(operand_valid), .op(op),
        .a(a), .b(b), .operand_last(operand_last), .ready(ready),
        .result_valid(result_valid), .result(result), .result_last(result_last),
        .result_rst(result_rst)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            2'd0:    return {32'b0, x} + {32'b0, y};
            2'd1:    return {32'b0, x} - {32'b0, y};
            2'd2:    return {32'b0, x} * {32'b0, y};
            default: return {32'b0, x ^ y};
        endcase
    endfunction

    // Output monitor: every result beat is matched against the scoreboard.
    always @(negedge clk) begin
        sb_entry_t e;
        if (rst) begin
            if (result_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("res_data", {56'b0, result}, {56'b0, e.data});
                    check("res_last", {63'b0, result_last}, {63'b0, e.last});
                end
            end else begin
                check("idle_outputs_zero", {55'b0, result_last, result}, 64'd0);
            end
            check("result_rst_timing", {63'b0, result_rst}, {63'b0, prev_last});
            prev_last = result_last;
        end else begin
            prev_last = 1'b0;
        end
    end

    // Caller must be at a falling edge; a beat shown while ready=1 is taken on the next rise.
    task automatic send_txn(input logic [1:0] t_op, input logic [31:0] ta, input logic [31:0] tb_v,
                            input int nbeats, input bit use_last, input bit gaps,
                            input logic [63:0] exp, output int lat);
        int n;
        for (int i = 0; i < 8; i++) sb.push_back('{exp[8*i +: 8], (i == 7)});
        for (int k = 0; k < nbeats; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            n = 0;
            while (!ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) check("ready_timeout", 64'd0, 64'd1);
            operand_valid = 1'b1;
            op            = (k == 0) ? t_op : ~t_op;
            a             = ta[8*k +: 8];
            b             = tb_v[8*k +: 8];
            operand_last  = use_last && (k == nbeats - 1);
            @(negedge clk);
            operand_valid = 1'b0;
            operand_last  = 1'b0;
            a             = 8'd0;
            b             = 8'd0;
        end
        lat = 1;
        while (!result_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Waits for the clear pulse, optionally hammering the input with beats that must be ignored.
    task automatic wait_done(input bit junk);
        int n = 0;
        while (!result_rst && n < 300) begin
            if (junk) begin
                operand_valid = 1'b1;
                operand_last  = 1'b1;
                op            = 2'($urandom);
                a             = 8'($urandom);
                b             = 8'($urandom);
            end
            @(negedge clk);
            n++;
        end
        operand_valid = 1'b0;
        operand_last  = 1'b0;
        check("result_rst_seen", {63'b0, result_rst}, 64'd1);
        check("ready_low_in_clr", {63'b0, ready}, 64'd0);
        @(negedge clk);
        check("result_rst_one_cycle", {63'b0, result_rst}, 64'd0);
        check("ready_after_clr", {63'b0, ready}, 64'd1);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          beats;
        int          n;
        logic [1:0]  r_op;
        int          r_nb;
        bit          r_last;
        logic [31:0] r_a, r_b, mask;

        #150;
        check("reset_outputs", {52'b0, ready, result_valid, result, result_last, result_rst}, 64'd0);
        #50;
        rst = 1'b1;
        #1;
        check("ready_before_edge", {63'b0, ready}, 64'd0);
        @(negedge clk);
        check("ready_after_release", {63'b0, ready}, 64'd1);

        send_txn(2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 4, 1'b1, 1'b0, 64'h0000_0001_0000_0000, lat);
        check("add_latency", 64'(lat), 64'd2);
        wait_done(1'b0);

        send_txn(2'd1, 32'h0000_0003, 32'h0000_0005, 1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, lat);
        check("sub_latency", 64'(lat), 64'd2);
        wait_done(1'b0);

        // Four beats without operand_last: the fourth is forced last.
        send_txn(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001, lat);
        check("mul_latency", 64'(lat), 64'd33);
        wait_done(1'b0);

        send_txn(2'd3, 32'h1234_5678, 32'hFFFF_0000, 4, 1'b1, 1'b1, 64'h0000_0000_EDCB_5678, lat);
        check("xor_latency", 64'(lat), 64'd2);
        wait_done(1'b1);

        for (int t = 0; t < 8; t++) begin
            r_op   = 2'($urandom_range(0, 3));
            r_nb   = $urandom_range(1, 4);
            r_last = (r_nb < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            mask   = (r_nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * r_nb)) - 32'h1);
            r_a    = $urandom & mask;
            r_b    = $urandom & mask;
            send_txn(r_op, r_a, r_b, r_nb, r_last, 1'b1, model(r_op, r_a, r_b), lat);
            check("rand_latency", 64'(lat), (r_op == 2'd2) ? 64'd33 : 64'd2);
            wait_done(1'($urandom_range(0, 1)));
        end

        // Abort during OUT after the third result beat.
        send_txn(2'd0, 32'h89AB_CDEF, 32'h1111_1111, 4, 1'b1, 1'b0, 64'h0000_0000_9ABC_DF00, lat);
        beats = result_valid ? 1 : 0;
        n = 0;
        while (beats < 3 && n < 20) begin
            @(negedge clk);
            if (result_valid) beats++;
            n++;
        end
        check("abort_beats_seen", 64'(beats), 64'd3);
        #2;
        rst = 1'b0;
        sb.delete();
        #1;
        check("abort_outputs_zero", {52'b0, ready, result_valid, result, result_last, result_rst}, 64'd0);
        repeat (3) begin
            @(negedge clk);
            check("abort_held_zero", {52'b0, ready, result_valid, result, result_last, result_rst}, 64'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_abort", {63'b0, ready}, 64'd1);
        repeat (3) @(negedge clk);

        send_txn(2'd0, 32'h0000_0001, 32'h0000_0001, 1, 1'b1, 1'b0, 64'h0000_0000_0000_0002, lat);
        check("post_abort_latency", 64'(lat), 64'd2);
        wait_done(1'b0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
